// File: rtl/kmeans_assign_ctrl.sv
// K-means assignment sequencer: reads each point, drives the 8-way distance
// datapath, writes the nearest active center as label and counts label changes.
module kmeans_assign_ctrl #(
  parameter int DEPTH     = 1024,
  parameter int LOG_DEPTH = 10,
  parameter int WIDTH     = 16,
  parameter int DIST_W    = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOG_DEPTH:0]   num_points,
  input  logic [3:0]           num_centers,
  output logic                 pt_rd_en,
  output logic [LOG_DEPTH-1:0] pt_addr,
  input  logic [WIDTH-1:0]     pt_x,
  input  logic [WIDTH-1:0]     pt_y,
  input  logic [2:0]           old_label,
  output logic [WIDTH-1:0]     pointx,
  output logic [WIDTH-1:0]     pointy,
  output logic                 dist_en,
  input  logic [DIST_W-1:0]    dist0,
  input  logic [DIST_W-1:0]    dist1,
  input  logic [DIST_W-1:0]    dist2,
  input  logic [DIST_W-1:0]    dist3,
  input  logic [DIST_W-1:0]    dist4,
  input  logic [DIST_W-1:0]    dist5,
  input  logic [DIST_W-1:0]    dist6,
  input  logic [DIST_W-1:0]    dist7,
  output logic                 lbl_we,
  output logic [LOG_DEPTH-1:0] lbl_addr,
  output logic [2:0]           lbl_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [LOG_DEPTH:0]   changed_cnt,
  output logic                 converged
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_DIST, S_CMP, S_DONE} state_t;

  localparam logic [LOG_DEPTH:0] MAX_PTS = (LOG_DEPTH+1)'(DEPTH);

  state_t                 state_r, state_s;
  logic [LOG_DEPTH-1:0]   idx_r;
  logic [LOG_DEPTH:0]     npts_r;
  logic [3:0]             keff_r;
  logic [2:0]             old_lbl_r;
  logic [LOG_DEPTH:0]     cnt_r;
  logic                   conv_r;
  logic [7:0][DIST_W-1:0] dvec_s;
  logic [2:0]             nearest_s;
  logic                   last_s;
  logic                   diff_s;
  logic [LOG_DEPTH:0]     cnt_next_s;

  // Active center count: 0 behaves as 1, anything above 8 behaves as 8.
  function automatic logic [3:0] clamp_k(input logic [3:0] nc);
    return (nc == 4'd0) ? 4'd1 : ((nc > 4'd8) ? 4'd8 : nc);
  endfunction

  // Unsigned argmin over the first k distances; strict compare keeps ties on the lowest index.
  function automatic logic [2:0] argmin(input logic [7:0][DIST_W-1:0] d, input logic [3:0] k);
    logic [DIST_W-1:0] best;
    logic [2:0]        sel;
    logic              take;
    best = d[0];
    sel  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      take = (4'(i) < k) && (d[i] < best);
      best = take ? d[i] : best;
      sel  = take ? 3'(i) : sel;
    end
    return sel;
  endfunction

  assign dvec_s     = {dist7, dist6, dist5, dist4, dist3, dist2, dist1, dist0};
  assign nearest_s  = argmin(dvec_s, keff_r);
  assign last_s     = ({1'b0, idx_r} == (npts_r - {{LOG_DEPTH{1'b0}}, 1'b1}));
  assign diff_s     = (nearest_s != old_lbl_r);
  assign cnt_next_s = cnt_r + {{LOG_DEPTH{1'b0}}, diff_s};

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = (num_points != '0) ? S_RD : S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD:   state_s = S_DIST;
      S_DIST: state_s = S_CMP;
      S_CMP: begin
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RD;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register plus pass bookkeeping (index, latched params, change count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      idx_r     <= '0;
      npts_r    <= '0;
      keff_r    <= 4'd1;
      old_lbl_r <= 3'd0;
      cnt_r     <= '0;
      conv_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            idx_r  <= '0;
            cnt_r  <= '0;
            npts_r <= (num_points > MAX_PTS) ? MAX_PTS : num_points;
            keff_r <= clamp_k(num_centers);
            conv_r <= (num_points == '0);
          end else begin
            conv_r <= conv_r;
          end
        end
        S_DIST: old_lbl_r <= old_label;
        S_CMP: begin
          cnt_r <= cnt_next_s;
          if (last_s) begin
            conv_r <= (cnt_next_s == '0);
          end else begin
            idx_r <= idx_r + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign pointx      = pt_x;
  assign pointy      = pt_y;
  assign pt_rd_en    = (state_r == S_RD);
  assign pt_addr     = idx_r;
  assign dist_en     = (state_r == S_DIST);
  assign lbl_we      = (state_r == S_CMP);
  assign lbl_addr    = idx_r;
  assign lbl_wdata   = (state_r == S_CMP) ? nearest_s : 3'd0;
  assign busy        = (state_r != S_IDLE);
  assign done        = (state_r == S_DONE);
  assign changed_cnt = cnt_r;
  assign converged   = conv_r;

endmodule

// File: tb/tb_kmeans_assign_ctrl.sv
// Scoreboard bench for kmeans_assign_ctrl with behavioural memories and distance datapath.
module tb_kmeans_assign_ctrl;
  localparam int DEPTH = 1024;
  localparam int LW    = 10;
  localparam int W     = 16;
  localparam int DW    = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic [LW:0]   num_points = '0;
  logic [3:0]    num_centers = 4'd0;
  logic          pt_rd_en;
  logic [LW-1:0] pt_addr;
  logic [W-1:0]  pt_x = '0;
  logic [W-1:0]  pt_y = '0;
  logic [2:0]    old_label = 3'd0;
  logic [W-1:0]  pointx, pointy;
  logic          dist_en;
  logic [DW-1:0] d [8];
  logic          lbl_we;
  logic [LW-1:0] lbl_addr;
  logic [2:0]    lbl_wdata;
  logic          busy, done;
  logic [LW:0]   changed_cnt;
  logic          converged;

  kmeans_assign_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_points(num_points),
    .num_centers(num_centers), .pt_rd_en(pt_rd_en), .pt_addr(pt_addr),
    .pt_x(pt_x), .pt_y(pt_y), .old_label(old_label), .pointx(pointx), .pointy(pointy),
    .dist_en(dist_en), .dist0(d[0]), .dist1(d[1]), .dist2(d[2]), .dist3(d[3]),
    .dist4(d[4]), .dist5(d[5]), .dist6(d[6]), .dist7(d[7]), .lbl_we(lbl_we),
    .lbl_addr(lbl_addr), .lbl_wdata(lbl_wdata), .busy(busy), .done(done),
    .changed_cnt(changed_cnt), .converged(converged)
  );

  int          px_mem [DEPTH];
  int          py_mem [DEPTH];
  int          lbl_mem [DEPTH];
  int          cx [8];
  int          cy [8];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  int          rd_cnt = 0;

  typedef struct { int addr; int lbl; } wr_t;
  typedef struct { int cnt; int conv; int cyc; int n; } done_t;
  wr_t   exp_wr [$];
  done_t exp_done [$];
  wr_t   mw;
  done_t md;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sqd(int px, int py, int i);
    longint dx, dy;
    dx = longint'(px) - longint'(cx[i]);
    dy = longint'(py) - longint'(cy[i]);
    return dx * dx + dy * dy;
  endfunction

  // Point/label memory with one-cycle read latency.
  always @(posedge clk) begin
    if (pt_rd_en) begin
      pt_x      <= W'(px_mem[pt_addr]);
      pt_y      <= W'(py_mem[pt_addr]);
      old_label <= 3'(lbl_mem[pt_addr]);
    end
  end

  // Distance datapath stand-in: registered squared distance to each center.
  always @(posedge clk) begin
    if (dist_en) begin
      for (int i = 0; i < 8; i++) d[i] <= DW'(sqd(int'(pointx), int'(pointy), i));
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int eff_k(int nc);
    if (nc == 0) return 1;
    if (nc > 8) return 8;
    return nc;
  endfunction

  // Nearest center by exhaustive search; first minimum wins.
  function automatic int ref_label(int a, int k);
    longint best;
    int     bi;
    best = sqd(px_mem[a], py_mem[a], 0);
    bi   = 0;
    for (int i = 1; i < k; i++) begin
      if (sqd(px_mem[a], py_mem[a], i) < best) begin
        best = sqd(px_mem[a], py_mem[a], i);
        bi   = i;
      end
    end
    return bi;
  endfunction

  // Monitor: pops expectations whenever the DUT writes a label or signals done.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
    end else begin
      if (pt_rd_en) rd_cnt++;
      if (lbl_we) begin
        chk("write_expected", longint'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          mw = exp_wr.pop_front();
          chk("wr_addr", longint'(lbl_addr), mw.addr);
          chk("wr_label", longint'(lbl_wdata), mw.lbl);
        end
      end
      if (done) begin
        chk("done_expected", longint'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          md = exp_done.pop_front();
          chk("changed_cnt", longint'(changed_cnt), md.cnt);
          chk("converged", longint'(converged), md.conv);
          chk("done_cycle", cyc, md.cyc);
          chk("read_count", rd_cnt, md.n);
          chk("writes_pending", exp_wr.size(), 0);
        end
        rd_cnt = 0;
        done_seen++;
      end
    end
  end

  // Queue expectations for a pass and issue start; returns expected change count.
  task automatic launch(input int n, input int nc, output int ecnt, output int new_lbl [DEPTH]);
    int k;
    done_t e;
    wr_t   w;
    k    = eff_k(nc);
    ecnt = 0;
    new_lbl = lbl_mem;
    for (int a = 0; a < n; a++) begin
      w.addr = a;
      w.lbl  = ref_label(a, k);
      new_lbl[a] = w.lbl;
      if (w.lbl != lbl_mem[a]) ecnt++;
      exp_wr.push_back(w);
    end
    @(negedge clk);
    e.cnt = ecnt; e.conv = (ecnt == 0) ? 1 : 0; e.cyc = cyc + 3 * n + 1; e.n = n;
    exp_done.push_back(e);
    num_points  = (LW+1)'(n);
    num_centers = 4'(nc);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    num_points  = (LW+1)'($urandom_range(0, DEPTH));
    num_centers = 4'($urandom_range(0, 15));
  endtask

  task automatic run_pass(input int n, input int nc, input bit poke);
    int ecnt;
    int base;
    int new_lbl [DEPTH];
    base = done_seen;
    launch(n, nc, ecnt, new_lbl);
    if (poke) begin
      @(negedge clk);
      chk("busy_mid_pass", longint'(busy), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 3 * n + 20 && done_seen == base; t++) @(negedge clk);
    chk("pass_finished", done_seen - base, 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_seen - base, 1);
    chk("cnt_hold", longint'(changed_cnt), ecnt);
    chk("conv_hold", longint'(converged), (ecnt == 0) ? 1 : 0);
    chk("busy_idle", longint'(busy), 0);
    exp_wr.delete();
    exp_done.delete();
    lbl_mem = new_lbl;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pt_rd_en"}, longint'(pt_rd_en), 0);
    chk({tag, "_pt_addr"}, longint'(pt_addr), 0);
    chk({tag, "_dist_en"}, longint'(dist_en), 0);
    chk({tag, "_lbl_we"}, longint'(lbl_we), 0);
    chk({tag, "_lbl_addr"}, longint'(lbl_addr), 0);
    chk({tag, "_lbl_wdata"}, longint'(lbl_wdata), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_changed_cnt"}, longint'(changed_cnt), 0);
    chk({tag, "_converged"}, longint'(converged), 0);
  endtask

  task automatic set_c(input int i, input int x, input int y);
    cx[i] = x;
    cy[i] = y;
  endtask

  task automatic rand_fill(input int n, input int lim);
    for (int a = 0; a < n; a++) begin
      px_mem[a]  = int'($urandom_range(0, lim));
      py_mem[a]  = int'($urandom_range(0, lim));
      lbl_mem[a] = int'($urandom_range(0, 7));
    end
    for (int i = 0; i < 8; i++) set_c(i, int'($urandom_range(0, lim)), int'($urandom_range(0, lim)));
  endtask

  initial begin
    int ecnt;
    int base;
    int nl [DEPTH];
    for (int a = 0; a < DEPTH; a++) begin px_mem[a] = 0; py_mem[a] = 0; lbl_mem[a] = 0; end
    for (int i = 0; i < 8; i++) set_c(i, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 rst_n = 1'b1;

    // Basic three-point case; c2 sits on a point but is masked by k=2.
    px_mem[0] = 0;  py_mem[0] = 0;
    px_mem[1] = 10; py_mem[1] = 10;
    px_mem[2] = 5;  py_mem[2] = 5;
    set_c(0, 1, 1); set_c(1, 9, 9); set_c(2, 5, 5);
    for (int i = 3; i < 8; i++) set_c(i, 10, 10);
    run_pass(3, 2, 1'b0);
    chk("lbl0", lbl_mem[0], 0);
    chk("lbl1", lbl_mem[1], 1);
    chk("lbl2", lbl_mem[2], 0);
    // Same data again: nothing changes, start pulse during the pass is ignored.
    run_pass(3, 2, 1'b1);

    // Tie between c0 and c1.
    px_mem[0] = 5; py_mem[0] = 0; lbl_mem[0] = 3;
    set_c(0, 0, 0); set_c(1, 10, 0);
    run_pass(1, 2, 1'b0);

    // k masking: c7 exactly on the point.
    px_mem[0] = 100; py_mem[0] = 100; lbl_mem[0] = 5;
    for (int i = 0; i < 7; i++) set_c(i, i * 3, 7);
    set_c(7, 100, 100);
    run_pass(1, 1, 1'b0);
    run_pass(1, 0, 1'b0);
    run_pass(1, 12, 1'b0);

    // Empty pass.
    run_pass(0, 3, 1'b0);

    // Randomized passes, small coordinate range for ties and full range for wide distances.
    for (int r = 0; r < 10; r++) begin
      rand_fill(int'($urandom_range(1, 40)), (r % 2 == 0) ? 15 : 65535);
      run_pass(int'($urandom_range(1, 40)), int'($urandom_range(0, 15)), r[0]);
    end

    // Abort a full-depth pass with reset.
    rand_fill(DEPTH, 255);
    base = done_seen;
    launch(DEPTH, 5, ecnt, nl);
    repeat (498) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    exp_wr.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", done_seen - base, 0);
    run_pass(DEPTH, int'($urandom_range(0, 15)), 1'b0);
    chk("final_pt_addr", longint'(pt_addr), DEPTH - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
